pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data payload width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port softReset  input  1  synchronous flush, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-009 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  head entry payload.
REQ-011 SHALL have port occupancy  output  2  entries held: 0, 1 or 2.

Function
REQ-012 SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready, both sampled at the rising edge.
REQ-013 SHALL implement states EMPTY (0 entries), BUSY (1 entry in main register) and FULL (main and skid registers both hold entries).
REQ-014 SHALL drive in_ready = 1 in EMPTY and BUSY and 0 in FULL, decoded from state only, with no combinational path from out_ready.
REQ-015 SHALL drive out_valid = 1 in BUSY and FULL, out_data = main register, and occupancy = 0/1/2 for EMPTY/BUSY/FULL.
REQ-016 EMPTY: on input transfer, load main with in_data and go to BUSY; otherwise hold.
REQ-017 BUSY with input and output transfer: load main with in_data and stay in BUSY (throughput 1/cycle).
REQ-018 BUSY with input transfer only: load skid with in_data and go to FULL.
REQ-019 BUSY with output transfer only: go to EMPTY.
REQ-020 FULL with output transfer: copy skid to main and go to BUSY; in_valid is ignored because in_ready = 0.
REQ-021 SHALL add a latency of exactly one cycle: data accepted at edge N is presented on out_data after edge N when the block was EMPTY.
REQ-022 SHALL preserve FIFO order; no entry is duplicated or dropped except by flush or reset.
REQ-023 softReset SHALL take priority over all transfers: next state EMPTY, any same-cycle input transfer discarded.
REQ-024 softReset SHALL leave main and skid data contents unchanged; only state is cleared.
REQ-025 out_data SHALL be don't-care when out_valid = 0, and the bench SHALL not check it.
REQ-026 A register SHALL load only in the cycles named above, so its contents hold while stalled (out_valid = 1, out_ready = 0).

Reset
REQ-027 reset = 0 SHALL immediately, without waiting for a clock edge, force state EMPTY, main = 0, skid = 0, and therefore in_ready = 1, out_valid = 0, occupancy = 0, out_data = 0.
REQ-028 On reset deassertion the block SHALL accept input on the first subsequent rising edge.
REQ-029 Reset asserted mid-transfer SHALL discard all held entries, with no partial state retained.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state enum type (EMPTY, BUSY, FULL) and the DEFAULT_WIDTH constant (32).
REQ-031 SHALL instantiate sub-module pipe_data_reg twice (main, skid); pipe_data_reg is a WIDTH-bit load-enable register with asynchronous active-low clear.
REQ-032 State encoding and next-state logic SHALL live in pipe_skid_reg itself.

Verification
REQ-033 Reset: assert reset = 0 mid-cycle -> out_valid = 0, in_ready = 1, occupancy = 0, out_data = 0 before the next edge.
REQ-034 Streaming: out_ready = 1, inject 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 on consecutive cycles with one-cycle latency and no bubbles.
REQ-035 Backpressure: out_ready = 0, inject 0xA1 then 0xA2 -> occupancy = 2, in_ready = 0, and 0xA3 is held off; raise out_ready -> outputs 0xA1, 0xA2, 0xA3 in order.
REQ-036 Flush: occupancy = 2, assert softReset with in_valid = 1 and in_data = 0xFF -> next cycle occupancy = 0, out_valid = 0, and 0xFF is never output.
REQ-037 Random: random in_valid and out_ready for 10k cycles -> scoreboard order matches, occupancy never exceeds 2, and in_ready never depends on same-cycle out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state type and default payload width for the skid pipeline register
package pipe_pkg;
    localparam int DEFAULT_WIDTH = 32;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;
endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: load-enable data register with asynchronous active-low clear
module pipe_data_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= '0;
        else if (i_load) r_q <= i_d;
    assign o_q = r_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid pipeline register with registered in_ready and synchronous flush
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             softReset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    state_t           r_state, w_next;
    logic             w_in_fire, w_out_fire, w_load_main, w_load_skid;
    logic [WIDTH-1:0] w_main_d, w_main_q, w_skid_q;

    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state == BUSY) || (r_state == FULL);
    assign out_data   = w_main_q;
    assign occupancy  = (r_state == FULL) ? 2'd2 : (r_state == BUSY) ? 2'd1 : 2'd0;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // A flush only clears state; data registers keep their contents
    always_comb begin
        w_next      = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_main_d    = (r_state == FULL) ? w_skid_q : in_data;
        if (softReset) w_next = EMPTY;
        else
            case (r_state)
                EMPTY: begin
                    w_load_main = w_in_fire;
                    w_next      = w_in_fire ? BUSY : EMPTY;
                end
                BUSY: begin
                    w_load_main = w_in_fire && w_out_fire;
                    w_load_skid = w_in_fire && !w_out_fire;
                    w_next      = (w_in_fire && !w_out_fire) ? FULL : (!w_in_fire && w_out_fire) ? EMPTY : BUSY;
                end
                FULL: begin
                    w_load_main = w_out_fire;
                    w_next      = w_out_fire ? BUSY : FULL;
                end
                default: w_next = EMPTY;
            endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= EMPTY;
        else r_state <= w_next;

    pipe_data_reg #(.WIDTH(WIDTH)) u_main (
        .clk(clk), .rst_n(reset), .i_load(w_load_main), .i_d(w_main_d), .o_q(w_main_q)
    );

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk(clk), .rst_n(reset), .i_load(w_load_skid), .i_d(in_data), .o_q(w_skid_q)
    );
endmodule
